nf10_barrier_stim_gate: RTL and testbench

- Per-port stimulus-side gate between an AXI4-Stream stimulus source and the DUT input port.
- Forwards stimulus beats through a one-deep registered output stage.
- Consumes in-band barrier marker beats and drives barrier_req and activity_stim for that port into the barrier block.
- Holds the stream stalled until the barrier block returns barrier_proceed.

---
 rtl/nf10_barrier_stim_gate.sv | 224 ++++++++++++++++++++++
 tb/tb_nf10_barrier_stim_gate.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/nf10_barrier_stim_gate.sv
// nf10_barrier_stim_gate
//   Stimulus-side barrier gate for one port. AXI4-Stream beats from the
//   stimulus source are forwarded to the DUT through a one-deep registered
//   output stage. In-band barrier marker beats (s_axis_tbarrier=1) are
//   swallowed. A marker makes the gate drain its output register, raise
//   barrier_req, and hold the stream stalled until the barrier block answers
//   with barrier_proceed. It then waits for proceed to drop before it
//   forwards again.
//
// Ports
//   clk, reset           single clock, synchronous active-high reset
//   s_axis_*             stimulus input (tdata/tstrb/tuser/tlast/tbarrier/
//                        tvalid in, tready out)
//   m_axis_*             registered output to the DUT
//   activity_stim        port busy: output valid or recent output transfer
//   barrier_req          high exactly while waiting at a barrier
//   barrier_proceed      global release from the barrier block
//   marker_err           sticky: a marker arrived inside a packet
//   barrier_timeout      sticky wait-limit flag (only with the macro below)
//
// Optional feature
//   Define NF10_BARRIER_STIM_TIMEOUT_EN to add barrier_timeout and the WAIT
//   cycle counter. C_TIMEOUT is only used in that build.
module nf10_barrier_stim_gate #(
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 128,
  parameter int C_IDLE_CYCLES = 16,
  parameter int C_TIMEOUT     = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [C_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tbarrier,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       activity_stim,
  output logic                       barrier_req,
  input  logic                       barrier_proceed,
`ifdef NF10_BARRIER_STIM_TIMEOUT_EN
  output logic                       barrier_timeout,
`endif
  output logic                       marker_err
);

  typedef enum logic [1:0] {
    ST_PASS    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] IDLE_RELOAD = 8'(C_IDLE_CYCLES);

  state_t                      state_q, state_d;
  logic                        valid_q, valid_d;
  logic [C_DATA_WIDTH-1:0]     tdata_q, tdata_d;
  logic [C_DATA_WIDTH/8-1:0]   tstrb_q, tstrb_d;
  logic [C_TUSER_WIDTH-1:0]    tuser_q, tuser_d;
  logic                        tlast_q, tlast_d;
  logic                        in_pkt_q, in_pkt_d;
  logic                        err_q, err_d;
  logic                        req_q, req_d;
  logic [7:0]                  idle_q, idle_d;
  logic                        act_q, act_d;

  logic accept_s;
  logic data_acc_s;
  logic mk_acc_s;
  logic m_xfer_s;

  // Only PASS takes beats; the register may reload while it empties.
  assign s_axis_tready = (state_q == ST_PASS) && (!valid_q || m_axis_tready);
  assign accept_s      = s_axis_tvalid && s_axis_tready;
  assign data_acc_s    = accept_s && !s_axis_tbarrier;
  assign mk_acc_s      = accept_s && s_axis_tbarrier;
  assign m_xfer_s      = valid_q && m_axis_tready;

  // Next-state logic of the barrier FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PASS: begin
        if (mk_acc_s) state_d = ST_DRAIN;
        else          state_d = ST_PASS;
      end
      ST_DRAIN: begin
        // Empty now or emptying on this edge both count as drained.
        if (!valid_q || m_xfer_s) state_d = ST_WAIT;
        else                      state_d = ST_DRAIN;
      end
      ST_WAIT: begin
        if (barrier_proceed) state_d = ST_RELEASE;
        else                 state_d = ST_WAIT;
      end
      ST_RELEASE: begin
        // Wait for proceed to fall so a stale proceed cannot release the next barrier.
        if (!barrier_proceed) state_d = ST_PASS;
        else                  state_d = ST_RELEASE;
      end
      default: state_d = ST_PASS;
    endcase
  end

  // FSM output decode: barrier_req is registered from the next state.
  always_comb begin
    req_d = (state_d == ST_WAIT);
  end

  // Output register, packet tracking, marker error and activity counter.
  always_comb begin
    valid_d  = valid_q;
    tdata_d  = tdata_q;
    tstrb_d  = tstrb_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    in_pkt_d = in_pkt_q;
    if (data_acc_s) begin
      valid_d = 1'b1;
      tdata_d = s_axis_tdata;
      tstrb_d = s_axis_tstrb;
      tuser_d = s_axis_tuser;
      tlast_d = s_axis_tlast;
    end else if (m_xfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (data_acc_s)    in_pkt_d = !s_axis_tlast;
    else if (mk_acc_s) in_pkt_d = 1'b0;
    else               in_pkt_d = in_pkt_q;

    err_d = err_q || (mk_acc_s && in_pkt_q);

    if (m_xfer_s)              idle_d = IDLE_RELOAD;
    else if (idle_q != 8'd0)   idle_d = idle_q - 8'd1;
    else                       idle_d = 8'd0;

    act_d = (idle_d != 8'd0) || valid_d;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_PASS;
      valid_q  <= 1'b0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
      in_pkt_q <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      idle_q   <= 8'd0;
      act_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      tdata_q  <= tdata_d;
      tstrb_q  <= tstrb_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      in_pkt_q <= in_pkt_d;
      err_q    <= err_d;
      req_q    <= req_d;
      idle_q   <= idle_d;
      act_q    <= act_d;
    end
  end

  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tstrb  = tstrb_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign barrier_req   = req_q;
  assign activity_stim = act_q;
  assign marker_err    = err_q;

`ifdef NF10_BARRIER_STIM_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LIM = 32'(C_TIMEOUT);

  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;

  // WAIT cycle counter and sticky timeout flag; the FSM is unaffected.
  always_comb begin
    if (state_q != ST_WAIT && state_d == ST_WAIT)
      wait_cnt_d = 32'd0;
    else if (state_q == ST_WAIT && wait_cnt_q < TIMEOUT_LIM)
      wait_cnt_d = wait_cnt_q + 32'd1;
    else
      wait_cnt_d = wait_cnt_q;
    timeout_d = timeout_q || (state_q == ST_WAIT && wait_cnt_d == TIMEOUT_LIM);
  end

  // Timeout registers plus a one-shot simulation message.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 32'd0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
`ifndef SYNTHESIS
      if (timeout_d && !timeout_q)
        $display("nf10_barrier_stim_gate: ERROR barrier wait exceeded %0d cycles", C_TIMEOUT);
`endif
    end
  end

  assign barrier_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_nf10_barrier_stim_gate.sv
module tb_nf10_barrier_stim_gate;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tstrb;
  logic [7:0]  s_axis_tuser;
  logic        s_axis_tlast, s_axis_tbarrier, s_axis_tvalid, s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb;
  logic [7:0]  m_axis_tuser;
  logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic        activity_stim, barrier_req, barrier_proceed, marker_err;
`ifdef NF10_BARRIER_STIM_TIMEOUT_EN
  logic        barrier_timeout;
`endif

  always #5 clk = ~clk;

  nf10_barrier_stim_gate #(
    .C_DATA_WIDTH (32),
    .C_TUSER_WIDTH(8),
    .C_IDLE_CYCLES(16),
    .C_TIMEOUT    (50)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tstrb   (s_axis_tstrb),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tbarrier(s_axis_tbarrier),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tstrb   (m_axis_tstrb),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .activity_stim  (activity_stim),
    .barrier_req    (barrier_req),
    .barrier_proceed(barrier_proceed),
`ifdef NF10_BARRIER_STIM_TIMEOUT_EN
    .barrier_timeout(barrier_timeout),
`endif
    .marker_err     (marker_err)
  );

  typedef struct {
    logic        rst, sv, sb, sl, mr, bp;
    logic [31:0] sd;
    logic        e_sr, e_mv, e_ml, e_req, e_act, e_err;
    logic [31:0] e_md;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cur   = -1;

  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  function automatic void add(input logic rst, input logic sv, input logic sb,
                              input logic sl, input logic [31:0] sd, input logic mr,
                              input logic bp, input logic e_sr, input logic e_mv,
                              input logic [31:0] e_md, input logic e_ml, input logic e_req,
                              input logic e_act, input logic e_err);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sb = sb; v.sl = sl; v.sd = sd; v.mr = mr; v.bp = bp;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_ml = e_ml;
    v.e_req = e_req; v.e_act = e_act; v.e_err = e_err;
    vq.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at vector %0d: got %0h, expected %0h", nm, cur, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset           = v.rst;
    s_axis_tvalid   = v.sv;
    s_axis_tbarrier = v.sb;
    s_axis_tlast    = v.sl;
    s_axis_tdata    = v.sd;
    s_axis_tuser    = v.sd[7:0];
    s_axis_tstrb    = 4'hF;
    m_axis_tready   = v.mr;
    barrier_proceed = v.bp;
    #1;
    check("s_tready", {31'd0, s_axis_tready}, {31'd0, v.e_sr});
    @(posedge clk);
    #1;
    check("m_tvalid", {31'd0, m_axis_tvalid}, {31'd0, v.e_mv});
    if (v.e_mv) begin
      check("m_tdata", m_axis_tdata, v.e_md);
      check("m_tuser", {24'd0, m_axis_tuser}, {24'd0, v.e_md[7:0]});
      check("m_tstrb", {28'd0, m_axis_tstrb}, 32'h0000_000F);
      check("m_tlast", {31'd0, m_axis_tlast}, {31'd0, v.e_ml});
    end
    check("barrier_req", {31'd0, barrier_req}, {31'd0, v.e_req});
    check("activity_stim", {31'd0, activity_stim}, {31'd0, v.e_act});
    check("marker_err", {31'd0, marker_err}, {31'd0, v.e_err});
    n_vec++;
  endtask

  initial begin
    // Three-beat packet, then the 16-cycle activity tail.
    add(0,1,0,0,32'hA000_0001,1,0, 1,1,32'hA000_0001,0,0,1,0);
    add(0,1,0,0,32'hA000_0002,1,0, 1,1,32'hA000_0002,0,0,1,0);
    add(0,1,0,1,32'hA000_0003,1,0, 1,1,32'hA000_0003,1,0,1,0);
    add(0,0,0,0,32'd0,1,0,         1,0,32'd0,0,0,1,0);
    for (int i = 0; i < 15; i++)
      add(0,0,0,0,32'd0,1,0,       1,0,32'd0,0,0,1,0);
    add(0,0,0,0,32'd0,1,0,         1,0,32'd0,0,0,0,0);
    add(0,0,0,0,32'd0,1,0,         1,0,32'd0,0,0,0,0);
    // Two-beat packet, marker, proceed for three cycles, resume.
    add(0,1,0,0,32'hB000_0001,1,0, 1,1,32'hB000_0001,0,0,1,0);
    add(0,1,0,1,32'hB000_0002,1,0, 1,1,32'hB000_0002,1,0,1,0);
    add(0,1,1,0,DEAD,1,0,          1,0,32'd0,0,0,1,0);
    add(0,0,0,0,32'd0,1,0,         0,0,32'd0,0,1,1,0);
    add(0,1,0,1,32'hC000_0001,1,0, 0,0,32'd0,0,1,1,0);
    add(0,1,0,1,32'hC000_0001,1,1, 0,0,32'd0,0,0,1,0);
    add(0,1,0,1,32'hC000_0001,1,1, 0,0,32'd0,0,0,1,0);
    add(0,1,0,1,32'hC000_0001,1,1, 0,0,32'd0,0,0,1,0);
    add(0,1,0,1,32'hC000_0001,1,0, 0,0,32'd0,0,0,1,0);
    add(0,1,0,1,32'hC000_0001,1,0, 1,1,32'hC000_0001,1,0,1,0);
    add(0,0,0,0,32'd0,1,0,         1,0,32'd0,0,0,1,0);
    // Buffered beat with m_tready low, marker pending, then release.
    add(0,1,0,1,32'hD000_0001,0,0, 1,1,32'hD000_0001,1,0,1,0);
    add(0,1,1,0,DEAD,0,0,          0,1,32'hD000_0001,1,0,1,0);
    add(0,1,1,0,DEAD,0,0,          0,1,32'hD000_0001,1,0,1,0);
    add(0,1,1,0,DEAD,1,0,          1,0,32'd0,0,0,1,0);
    add(0,0,0,0,32'd0,1,0,         0,0,32'd0,0,1,1,0);
    add(0,0,0,0,32'd0,1,1,         0,0,32'd0,0,0,1,0);
    add(0,0,0,0,32'd0,1,0,         0,0,32'd0,0,0,1,0);
    // Marker inside a packet sets the sticky error.
    add(0,1,0,0,32'hE000_0001,1,0, 1,1,32'hE000_0001,0,0,1,0);
    add(0,1,1,0,DEAD,1,0,          1,0,32'd0,0,0,1,1);
    add(0,0,0,0,32'd0,1,0,         0,0,32'd0,0,1,1,1);
    add(0,0,0,0,32'd0,1,1,         0,0,32'd0,0,0,1,1);
    add(0,0,0,0,32'd0,1,0,         0,0,32'd0,0,0,1,1);
    add(0,1,0,1,32'hF000_0001,1,0, 1,1,32'hF000_0001,1,0,1,1);
    add(0,0,0,0,32'd0,1,0,         1,0,32'd0,0,0,1,1);
    // Proceed ignored in PASS; back-to-back markers with stale proceed.
    add(0,0,0,0,32'd0,1,1,         1,0,32'd0,0,0,1,1);
    add(0,1,1,0,DEAD,1,0,          1,0,32'd0,0,0,1,1);
    add(0,1,1,0,DEAD,1,1,          0,0,32'd0,0,1,1,1);
    add(0,1,1,0,DEAD,1,1,          0,0,32'd0,0,0,1,1);
    add(0,1,1,0,DEAD,1,1,          0,0,32'd0,0,0,1,1);
    add(0,1,1,0,DEAD,1,0,          0,0,32'd0,0,0,1,1);
    add(0,1,1,0,DEAD,1,0,          1,0,32'd0,0,0,1,1);
    add(0,0,0,0,32'd0,1,0,         0,0,32'd0,0,1,1,1);
    add(0,0,0,0,32'd0,1,0,         0,0,32'd0,0,1,1,1);
    add(0,0,0,0,32'd0,1,1,         0,0,32'd0,0,0,1,1);
    add(0,0,0,0,32'd0,1,0,         0,0,32'd0,0,0,1,1);
    // Reset while in WAIT, then reset discarding a buffered beat.
    add(0,1,1,0,DEAD,1,0,          1,0,32'd0,0,0,1,1);
    add(0,0,0,0,32'd0,1,0,         0,0,32'd0,0,1,1,1);
    add(1,0,0,0,32'd0,0,0,         0,0,32'd0,0,0,0,0);
    add(0,0,0,0,32'd0,0,0,         1,0,32'd0,0,0,0,0);
    add(0,1,0,0,32'h1000_0001,0,0, 1,1,32'h1000_0001,0,0,1,0);
    add(1,1,0,0,32'h1000_0002,0,0, 0,0,32'd0,0,0,0,0);
    add(0,0,0,0,32'd0,1,0,         1,0,32'd0,0,0,0,0);

    // Initial reset sequence.
    reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tbarrier = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = 32'd0; s_axis_tuser = 8'd0; s_axis_tstrb = 4'hF;
    m_axis_tready = 1'b0; barrier_proceed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst barrier_req", {31'd0, barrier_req}, 32'd0);
    check("rst activity_stim", {31'd0, activity_stim}, 32'd0);
    check("rst marker_err", {31'd0, marker_err}, 32'd0);
    check("rst s_tready", {31'd0, s_axis_tready}, 32'd1);
    n_vec++;

    foreach (vq[i]) begin
      cur = i;
      apply(vq[i]);
    end

`ifdef NF10_BARRIER_STIM_TIMEOUT_EN
    begin
      vec_t v;
      cur = 1000;
      v = '{rst:1'b0, sv:1'b1, sb:1'b1, sl:1'b0, mr:1'b1, bp:1'b0, sd:DEAD,
            e_sr:1'b1, e_mv:1'b0, e_ml:1'b0, e_req:1'b0, e_act:1'b0, e_err:1'b0, e_md:32'd0};
      apply(v);
      v.sv = 1'b0; v.sb = 1'b0; v.e_sr = 1'b0; v.e_req = 1'b1;
      apply(v);
      for (int k = 0; k < 49; k++) apply(v);
      check("timeout early", {31'd0, barrier_timeout}, 32'd0);
      apply(v);
      check("timeout set", {31'd0, barrier_timeout}, 32'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
